// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage data port: single-cycle stores, RD_LAT-cycle loads, DERR on bad requests.
// Optional zero-fill of the RAM after reset is enabled by defining DMEM_INIT_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TRANDATADDR,
    input  logic        WRITEMEM,
    input  logic        SORL,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] MEMDATAI,
    output logic        DSTALL,
    output logic        DERR
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned OFF_HI = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;

`ifdef DMEM_INIT_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_rdata;
    logic              r_derr;
`ifdef DMEM_INIT_EN
    logic [ADDR_W-1:0] r_clr_idx;
`endif

    logic [31:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic              w_err;
    logic              w_load;
    logic              w_store;
    logic              w_bad;
    logic              w_addr_hit;
    logic              w_we;
    logic [ADDR_W-1:0] w_widx;
    logic [31:0]       w_wdata;

    // Address decode; the subtraction wraps so addresses below BASE land out of range.
    always_comb begin
        w_off      = DADDR - BASE;
        w_idx      = w_off[OFF_HI-1:2];
        w_oor      = (w_off >> OFF_HI) != 32'd0;
        w_err      = (DADDR[1:0] != 2'b00) || w_oor || (SORL != WRITEMEM);
        w_load     = TRANDATADDR && !WRITEMEM && !w_err;
        w_store    = TRANDATADDR && WRITEMEM && !w_err;
        w_bad      = TRANDATADDR && w_err;
        w_addr_hit = (DADDR == r_addr);
    end

    // RAM write port: accepted stores, or the zero-fill sweep.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_idx;
        w_wdata = DATAO;
        if (r_state == S_IDLE && w_store) begin
            w_we = 1'b1;
        end
`ifdef DMEM_INIT_EN
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_widx  = r_clr_idx;
            w_wdata = 32'd0;
        end
`endif
        if (!reset) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    // The load's first stall cycle is raised combinationally so the pipeline freezes immediately.
    always_comb begin
        DSTALL = 1'b0;
        case (r_state)
            S_IDLE:  DSTALL = reset && w_load;
            S_WAIT:  DSTALL = 1'b1;
            S_CLEAR: DSTALL = 1'b1;
            default: DSTALL = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_derr  <= 1'b0;
`ifdef DMEM_INIT_EN
            r_clr_idx <= '0;
`endif
        end else begin
            r_derr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_bad) begin
                        r_derr  <= 1'b1;
                        r_rdata <= '0;
                    end else if (w_load) begin
                        r_addr <= DADDR;
                        r_idx  <= w_idx;
                        r_cnt  <= CNT_W'(RD_LAT - 1);
                        if (RD_LAT <= 1) begin
                            r_rdata <= r_mem[w_idx];
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // A dropped or redirected request is a pipeline flush: abandon the load.
                    if (!TRANDATADDR || !w_addr_hit) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= r_mem[r_idx];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!(TRANDATADDR && !WRITEMEM && w_addr_hit)) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef DMEM_INIT_EN
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + ADDR_W'(1);
                    if (&r_clr_idx) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MEMDATAI = r_rdata;
    assign DERR     = r_derr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (RD_LAT 1 and 3) share stimulus; a word-array model predicts results.
module tb_dmem_responder;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0100;
`ifdef DMEM_INIT_EN
    localparam logic EXP_RST_STALL = 1'b1;
    localparam int   EXP_CLR       = DEPTH;
`else
    localparam logic EXP_RST_STALL = 1'b0;
    localparam int   EXP_CLR       = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tv, twm, tso;
    logic [31:0] taddr, tdata;
    logic [31:0] md1, md3;
    logic        st1, st3, er1, er3;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .RD_LAT(1), .BASE(BASE)) u_dut1 (
        .clk(clk), .reset(reset), .TRANDATADDR(tv), .WRITEMEM(twm), .SORL(tso),
        .DADDR(taddr), .DATAO(tdata), .MEMDATAI(md1), .DSTALL(st1), .DERR(er1)
    );

    dmem_responder #(.ADDR_W(AW), .RD_LAT(3), .BASE(BASE)) u_dut3 (
        .clk(clk), .reset(reset), .TRANDATADDR(tv), .WRITEMEM(twm), .SORL(tso),
        .DADDR(taddr), .DATAO(tdata), .MEMDATAI(md3), .DSTALL(st3), .DERR(er3)
    );

    function automatic bit is_err(input logic [31:0] a, input logic wm, input logic so);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH)) || (wm != so);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off) % DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_INIT_EN
            m_mem[i] = 32'd0;
            m_vld[i] = 1'b1;
`else
            m_vld[i] = 1'b0;
`endif
        end
    endtask

    // One clock cycle: drive at negedge, sample the combinational stall, then settle after posedge.
    task automatic step(input logic v, input logic wm, input logic so, input logic [31:0] a,
                        input logic [31:0] d, output logic s1, output logic s3);
        @(negedge clk);
        tv = v; twm = wm; tso = so; taddr = a; tdata = d;
        #1;
        s1 = st1;
        s3 = st3;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic s1, s3;
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, s1, s3);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        logic s1, s3;
        step(1'b1, 1'b1, 1'b1, a, d, s1, s3);
        if (!is_err(a, 1'b1, 1'b1)) m_mem[idx_of(a)] = d;
        if (!is_err(a, 1'b1, 1'b1)) m_vld[idx_of(a)] = 1'b1;
        idle();
    endtask

    task automatic load_run(input logic [31:0] a, input int hold, output int n1, output int n3, output int ne);
        logic s1, s3;
        n1 = 0; n3 = 0; ne = 0;
        for (int i = 0; i < hold; i++) begin
            step(1'b1, 1'b0, 1'b0, a, 32'd0, s1, s3);
            n1 += int'(s1);
            n3 += int'(s3);
            if (er1 !== 1'b0 || er3 !== 1'b0) ne++;
        end
        idle();
    endtask

    // Called right after reset release at a negedge; counts stalled cycles before both instances are ready.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            #1;
            if (st1 === 1'b0 && st3 === 1'b0) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        tv = 1'b0; twm = 1'b0; tso = 1'b0; taddr = 32'd0; tdata = 32'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++; if (md1 !== 32'd0 || md3 !== 32'd0) begin bad++; $display("FAIL reset_memdatai: got %h/%h expected 0", md1, md3); end
        total++; if (er1 !== 1'b0 || er3 !== 1'b0) begin bad++; $display("FAIL reset_derr: got %b/%b expected 0", er1, er3); end
        total++; if (st1 !== EXP_RST_STALL || st3 !== EXP_RST_STALL) begin bad++; $display("FAIL reset_dstall: got %b/%b expected %b", st1, st3, EXP_RST_STALL); end
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        total++; if (n != EXP_CLR) begin bad++; $display("FAIL reset_ready: stall cycles %0d expected %0d", n, EXP_CLR); end
    endtask

    task automatic test_store_load();
        int n1, n3, ne;
        store(BASE + 32'h10, 32'hDEAD_BEEF);
        load_run(BASE + 32'h10, 4, n1, n3, ne);
        total++; if (n1 != 1) begin bad++; $display("FAIL sl_stall1: got %0d expected 1", n1); end
        total++; if (n3 != 3) begin bad++; $display("FAIL sl_stall3: got %0d expected 3", n3); end
        total++; if (ne != 0) begin bad++; $display("FAIL sl_derr: got %0d pulses expected 0", ne); end
        total++; if (md1 !== m_mem[4] || md3 !== m_mem[4]) begin bad++; $display("FAIL sl_data: got %h/%h expected %h", md1, md3, m_mem[4]); end
    endtask

    task automatic test_held_load();
        logic s1, s3;
        store(BASE + 32'h20, 32'h1234_5678);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 1'b0, BASE + 32'h20, 32'd0, s1, s3);
            total++; if (s3 !== (k < 3) || s1 !== (k < 1)) begin bad++; $display("FAIL held_stall c%0d: got %b/%b expected %b/%b", k, s1, s3, k < 1, k < 3); end
            if (k >= 2) begin
                total++; if (md3 !== 32'h1234_5678 || md1 !== 32'h1234_5678) begin bad++; $display("FAIL held_data c%0d: got %h/%h expected 12345678", k, md1, md3); end
            end
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] ea [4];
        logic        ew [4];
        logic        es [4];
        logic        s1, s3;
        int          n1, n3, ne;
        ea[0] = BASE + 32'h22;           ew[0] = 1'b0; es[0] = 1'b0;
        ea[1] = BASE + 32'(4 * DEPTH);   ew[1] = 1'b1; es[1] = 1'b1;
        ea[2] = BASE + 32'h20;           ew[2] = 1'b1; es[2] = 1'b0;
        ea[3] = BASE - 32'd4;            ew[3] = 1'b0; es[3] = 1'b0;
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 2; c++) begin
                step(1'b1, ew[e], es[e], ea[e], 32'hFFFF_FFFF, s1, s3);
                total++; if (er1 !== 1'b1 || er3 !== 1'b1 || s1 !== 1'b0 || s3 !== 1'b0) begin bad++; $display("FAIL err%0d_c%0d: derr %b/%b stall %b/%b expected derr 1 stall 0", e, c, er1, er3, s1, s3); end
                total++; if (md1 !== 32'd0 || md3 !== 32'd0) begin bad++; $display("FAIL err%0d_data: got %h/%h expected 0", e, md1, md3); end
            end
            idle();
            total++; if (er1 !== 1'b0 || er3 !== 1'b0) begin bad++; $display("FAIL err%0d_drop: derr %b/%b expected 0", e, er1, er3); end
        end
        load_run(BASE + 32'h20, 4, n1, n3, ne);
        total++; if (md1 !== 32'h1234_5678 || md3 !== 32'h1234_5678) begin bad++; $display("FAIL err_readback: got %h/%h expected 12345678", md1, md3); end
    endtask

    task automatic test_abort();
        logic s1, s3;
        int   n1, n3;
        store(BASE + 32'h24, 32'hCAFE_0024);
        step(1'b1, 1'b0, 1'b0, BASE + 32'h20, 32'd0, s1, s3);
        n1 = int'(s1); n3 = int'(s3);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, BASE + 32'h24, 32'd0, s1, s3);
            n1 += int'(s1); n3 += int'(s3);
        end
        // The slow instance aborts after two stall cycles, then restarts a full load; the fast one finished the first load already.
        total++; if (n3 != 2 + 3) begin bad++; $display("FAIL abort_stall3: got %0d expected 5", n3); end
        total++; if (n1 != 1 + 1) begin bad++; $display("FAIL abort_stall1: got %0d expected 2", n1); end
        total++; if (md1 !== 32'hCAFE_0024 || md3 !== 32'hCAFE_0024) begin bad++; $display("FAIL abort_data: got %h/%h expected cafe0024", md1, md3); end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        logic s1, s3;
        int   n, n1, n3, ne;
        step(1'b1, 1'b0, 1'b0, BASE + 32'h20, 32'd0, s1, s3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++; if (md1 !== 32'd0 || md3 !== 32'd0) begin bad++; $display("FAIL rstw_data: got %h/%h expected 0", md1, md3); end
        total++; if (st1 !== EXP_RST_STALL || st3 !== EXP_RST_STALL) begin bad++; $display("FAIL rstw_stall: got %b/%b expected %b", st1, st3, EXP_RST_STALL); end
        @(negedge clk);
        tv = 1'b0;
        reset = 1'b1;
`ifdef DMEM_INIT_EN
        model_clear();
`endif
        wait_ready(n);
        total++; if (n != EXP_CLR) begin bad++; $display("FAIL rstw_ready: stall cycles %0d expected %0d", n, EXP_CLR); end
        load_run(BASE + 32'h10, 4, n1, n3, ne);
        total++; if (md1 !== m_mem[4] || md3 !== m_mem[4]) begin bad++; $display("FAIL rstw_reload: got %h/%h expected %h", md1, md3, m_mem[4]); end
        total++; if (n3 != 3) begin bad++; $display("FAIL rstw_stall3: got %0d expected 3", n3); end
    endtask

`ifdef DMEM_INIT_EN
    task automatic test_clear();
        int n1, n3, ne;
        load_run(BASE + 32'h3C, 4, n1, n3, ne);
        total++; if (md1 !== 32'd0 || md3 !== 32'd0) begin bad++; $display("FAIL clear_data: got %h/%h expected 0", md1, md3); end
    endtask
`endif

    task automatic test_random();
        logic        s1, s3, wm, so, e;
        logic [31:0] a, d;
        int          op, ix, n1, n3, ne;
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 9));
            ix = int'($urandom_range(0, DEPTH - 1));
            a  = BASE + (32'(ix) << 2);
            if (op < 4) begin
                d = $urandom;
                step(1'b1, 1'b1, 1'b1, a, d, s1, s3);
                total++; if (er1 !== 1'b0 || er3 !== 1'b0 || s1 !== 1'b0 || s3 !== 1'b0) begin bad++; $display("FAIL rnd_store%0d: derr %b/%b stall %b/%b expected 0", t, er1, er3, s1, s3); end
                m_mem[ix] = d;
                m_vld[ix] = 1'b1;
                idle();
            end else if (op < 8) begin
                load_run(a, 4, n1, n3, ne);
                total++; if (n1 != 1 || n3 != 3 || ne != 0) begin bad++; $display("FAIL rnd_load%0d: stalls %0d/%0d derr %0d expected 1/3/0", t, n1, n3, ne); end
                if (m_vld[ix]) begin
                    total++; if (md1 !== m_mem[ix] || md3 !== m_mem[ix]) begin bad++; $display("FAIL rnd_data%0d: got %h/%h expected %h", t, md1, md3, m_mem[ix]); end
                end
            end else begin
                wm = 1'(($urandom >> 4) & 1);
                so = wm;
                case ($urandom_range(0, 2))
                    0:       a = a + 32'($urandom_range(1, 3));
                    1:       a = a + 32'(4 * DEPTH);
                    default: so = ~wm;
                endcase
                e = is_err(a, wm, so);
                step(1'b1, wm, so, a, 32'h5A5A_5A5A, s1, s3);
                total++; if (er1 !== e || er3 !== e || s1 !== 1'b0 || s3 !== 1'b0) begin bad++; $display("FAIL rnd_err%0d: derr %b/%b stall %b/%b expected derr %b stall 0", t, er1, er3, s1, s3, e); end
                idle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_held_load();
        test_errors();
        test_abort();
        test_reset_mid_wait();
`ifdef DMEM_INIT_EN
        test_clear();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
